// File: rtl/sat_add_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_add_arbiter_pkg: saturation flag encodings and clog2 helper   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package sat_add_arbiter_pkg;

    localparam logic [1:0] SAT_NONE = 2'b00;
    localparam logic [1:0] SAT_POS  = 2'b01;
    localparam logic [1:0] SAT_NEG  = 2'b10;

    // Never returns less than 1 so index ports always have a legal width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_add_arbiter_sat_add.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_add: combinational signed adder clamping to the type range    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sat_add
    import sat_add_arbiter_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    output logic [BITWIDTH-1:0] sum,
    output logic [1:0]          sat
);

    logic [BITWIDTH:0] w_wide;

    assign w_wide = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};

    always_comb begin
        sum = w_wide[BITWIDTH-1:0];
        sat = SAT_NONE;
        case (w_wide[BITWIDTH:BITWIDTH-1])
            2'b01: begin
                sum = {1'b0, {(BITWIDTH-1){1'b1}}};
                sat = SAT_POS;
            end
            2'b10: begin
                sum = {1'b1, {(BITWIDTH-1){1'b0}}};
                sat = SAT_NEG;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sat_add_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_add_arbiter: round-robin requesters feeding one saturating    |
// | adder with a single-entry result register. Rev 1.0                |
// +------------------------------------------------------------------+
module sat_add_arbiter
    import sat_add_arbiter_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int NREQ     = 4,
    parameter int CNTW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*BITWIDTH-1:0] req_a,
    input  logic [NREQ*BITWIDTH-1:0] req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [BITWIDTH-1:0]      res_data,
    output logic [clog2(NREQ)-1:0]   res_id,
    output logic [1:0]               res_sat,
    input  logic                     stat_clr,
    output logic [CNTW-1:0]          stat_cnt
);

    localparam int IDW = clog2(NREQ);

    logic [IDW-1:0]      r_last_grant;
    logic                r_valid;
    logic [BITWIDTH-1:0] r_data;
    logic [IDW-1:0]      r_id;
    logic [1:0]          r_sat;
    logic [CNTW-1:0]     r_stat_cnt;

    logic                w_slot_free;
    logic                w_found;
    logic [IDW-1:0]      w_grant;
    logic [IDW-1:0]      w_cand;
    logic                w_req_xfer;
    logic                w_res_xfer;
    logic                w_sat_inc;
    logic [BITWIDTH-1:0] w_a;
    logic [BITWIDTH-1:0] w_b;
    logic [BITWIDTH-1:0] w_sum;
    logic [1:0]          w_sat;

    assign w_slot_free = !r_valid || res_ready;

    // Rotating priority: the search starts just past the last grant.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_last_grant) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_found && w_slot_free && !rst) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_req_xfer = |(req_valid & req_ready);
    assign w_res_xfer = r_valid && res_ready;
    assign w_sat_inc  = w_res_xfer && (r_sat != SAT_NONE);

    assign w_a = req_a[int'(w_grant)*BITWIDTH +: BITWIDTH];
    assign w_b = req_b[int'(w_grant)*BITWIDTH +: BITWIDTH];

    sat_add #(
        .BITWIDTH (BITWIDTH)
    ) u_sat_add (
        .a   (w_a),
        .b   (w_b),
        .sum (w_sum),
        .sat (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_id         <= '0;
            r_sat        <= SAT_NONE;
            r_last_grant <= IDW'(NREQ - 1);
        end else if (w_req_xfer) begin
            r_valid      <= 1'b1;
            r_data       <= w_sum;
            r_id         <= w_grant;
            r_sat        <= w_sat;
            r_last_grant <= w_grant;
        end else if (w_res_xfer) begin
            r_valid <= 1'b0;
        end
    end

    // A clear coinciding with a counted transfer leaves that transfer counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cnt <= '0;
        end else if (stat_clr) begin
            r_stat_cnt <= w_sat_inc ? CNTW'(1) : '0;
        end else if (w_sat_inc && (r_stat_cnt != '1)) begin
            r_stat_cnt <= r_stat_cnt + CNTW'(1);
        end
    end

    assign res_valid = r_valid;
    assign res_data  = r_data;
    assign res_id    = r_id;
    assign res_sat   = r_sat;
    assign stat_cnt  = r_stat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sat_add_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sat_add_arbiter: directed vectors with hand-computed results   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_sat_add_arbiter;

    localparam int BITWIDTH = 32;
    localparam int NREQ     = 4;
    localparam int CNTW     = 4;

    logic                     clk;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*BITWIDTH-1:0] req_a;
    logic [NREQ*BITWIDTH-1:0] req_b;
    logic                     res_valid;
    logic                     res_ready;
    logic [BITWIDTH-1:0]      res_data;
    logic [1:0]               res_id;
    logic [1:0]               res_sat;
    logic                     stat_clr;
    logic [CNTW-1:0]          stat_cnt;

    int vectors;
    int miscompares;

    sat_add_arbiter #(
        .BITWIDTH (BITWIDTH),
        .NREQ     (NREQ),
        .CNTW     (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_sat   (res_sat),
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*BITWIDTH +: BITWIDTH] = a;
        req_b[i*BITWIDTH +: BITWIDTH] = b;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        res_ready   = 1'b0;
        stat_clr    = 1'b0;

        // Reset state
        tick();
        tick();
        req_valid = 4'hF;
        settle();
        chk("rst_ready",     64'(req_ready), 64'h0);
        chk("rst_res_valid", 64'(res_valid), 64'h0);
        chk("rst_res_data",  64'(res_data),  64'h0);
        chk("rst_res_id",    64'(res_id),    64'h0);
        chk("rst_res_sat",   64'(res_sat),   64'h0);
        chk("rst_stat_cnt",  64'(stat_cnt),  64'h0);

        // Round-robin with all requesters valid
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 16), 32'h1);
        res_ready = 1'b1;
        rst       = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
            tick();
            chk("rr_valid", 64'(res_valid), 64'h1);
            chk("rr_id",    64'(res_id),    64'(k % 4));
            chk("rr_data",  64'(res_data),  64'((k % 4) * 16 + 1));
        end
        req_valid = '0;
        tick();
        chk("drain_valid", 64'(res_valid), 64'h0);
        chk("drain_hold",  64'(res_data),  64'h1);

        // Positive clamp from requester 1
        res_ready = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 32'h7FFF_FFFF, 32'h0000_0001);
        settle();
        chk("pos_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        chk("pos_data", 64'(res_data), 64'h7FFF_FFFF);
        chk("pos_sat",  64'(res_sat),  64'h1);
        chk("pos_id",   64'(res_id),   64'h1);
        chk("pos_cnt0", 64'(stat_cnt), 64'h0);
        res_ready = 1'b1;
        tick();
        chk("pos_cnt1",  64'(stat_cnt),  64'h1);
        chk("pos_valid", 64'(res_valid), 64'h0);

        // Negative clamp then exact result, back-to-back from requester 2
        req_valid = 4'b0100;
        set_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        chk("neg_data", 64'(res_data), 64'h8000_0000);
        chk("neg_sat",  64'(res_sat),  64'h2);
        chk("neg_id",   64'(res_id),   64'h2);
        set_op(2, 32'hFFFF_FFFE, 32'h0000_0003);
        tick();
        chk("exact_data", 64'(res_data), 64'h1);
        chk("exact_sat",  64'(res_sat),  64'h0);
        chk("exact_cnt",  64'(stat_cnt), 64'h2);
        req_valid = '0;
        tick();
        chk("exact_nocnt", 64'(stat_cnt), 64'h2);

        // Backpressure holds the result and blocks grants
        req_valid = 4'b0001;
        set_op(0, 32'h5, 32'h6);
        tick();
        chk("bp_first", 64'(res_data), 64'hB);
        res_ready = 1'b0;
        set_op(0, 32'h100, 32'h1);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_ready", 64'(req_ready), 64'h0);
            tick();
            chk("bp_valid", 64'(res_valid), 64'h1);
            chk("bp_data",  64'(res_data),  64'hB);
            chk("bp_id",    64'(res_id),    64'h0);
        end
        res_ready = 1'b1;
        settle();
        chk("bp_release_ready", 64'(req_ready), 64'h1);
        tick();
        chk("bp_new_data",  64'(res_data),  64'h101);
        chk("bp_new_valid", 64'(res_valid), 64'h1);
        req_valid = '0;
        tick();

        // Clear coinciding with a saturated transfer
        res_ready = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        tick();
        chk("clr_setup_sat", 64'(res_sat), 64'h1);
        req_valid = '0;
        res_ready = 1'b1;
        stat_clr  = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_same_cycle", 64'(stat_cnt), 64'h1);

        // Counter saturates at all-ones
        req_valid = 4'b0001;
        set_op(0, 32'h8000_0000, 32'h8000_0000);
        for (int k = 0; k < (1 << CNTW) + 5; k++) tick();
        req_valid = '0;
        tick();
        chk("cnt_sat",      64'(stat_cnt), 64'hF);
        chk("cnt_sat_data", 64'(res_data), 64'h8000_0000);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_plain", 64'(stat_cnt), 64'h0);

        // Reset overrides an in-flight saturated result
        res_ready = 1'b0;
        req_valid = 4'hF;
        set_op(1, 32'h7FFF_FFFF, 32'h1);
        tick();
        chk("rst2_pre_id",  64'(res_id),    64'h1);
        chk("rst2_pre_val", 64'(res_valid), 64'h1);
        rst       = 1'b1;
        res_ready = 1'b1;
        settle();
        chk("rst2_ready", 64'(req_ready), 64'h0);
        tick();
        chk("rst2_valid", 64'(res_valid), 64'h0);
        chk("rst2_cnt",   64'(stat_cnt),  64'h0);
        chk("rst2_data",  64'(res_data),  64'h0);
        rst = 1'b0;
        settle();
        chk("rst2_first_ready", 64'(req_ready), 64'h1);
        tick();
        chk("rst2_first_id",  64'(res_id),    64'h0);
        chk("rst2_first_val", 64'(res_valid), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
